// File: rtl/d16_fetch_pkg.sv
// Shared defaults for the d16 fetch unit: bus widths, queue depth, PC step and reset vector.
package d16_fetch_pkg;
  localparam int D16_ADDR_W     = 16;
  localparam int D16_INS_W      = 32;
  localparam int D16_DEPTH      = 4;
  localparam int D16_INS_STEP   = 4;
  localparam int D16_RESET_ADDR = 0;

  // Occupancy counter width: must be able to represent a completely full queue.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/d16_fetch_if.sv
// Fetch unit bus: the instruction-memory read port, the jump input and the decode-side handshake.
interface d16_fetch_if
  import d16_fetch_pkg::*;
#(
  parameter int ADDR_W = D16_ADDR_W,
  parameter int INS_W  = D16_INS_W,
  parameter int DEPTH  = D16_DEPTH
) ();
  logic [ADDR_W-1:0]         ins_a;
  logic                      ins_re;
  logic [INS_W-1:0]          ins_di;
  logic                      jmp;
  logic [ADDR_W-1:0]         jmp_adr;
  logic                      out_valid;
  logic [INS_W-1:0]          out_ins;
  logic [ADDR_W-1:0]         out_pc;
  logic                      out_ready;
  logic [lvl_w(DEPTH)-1:0]   level;

  modport master (
    output ins_a, ins_re, out_valid, out_ins, out_pc, level,
    input  ins_di, jmp, jmp_adr, out_ready
  );

  modport slave (
    input  ins_a, ins_re, out_valid, out_ins, out_pc, level,
    output ins_di, jmp, jmp_adr, out_ready
  );
endinterface

// File: rtl/d16_fifo.sv
// Synchronous FIFO with flush and a registered head; push-to-head latency 1 cycle.
// A push into a full queue is a caller error and is flagged in simulation.
module d16_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       valid,
  output logic [WIDTH-1:0]           head
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_pop;

  assign do_pop = pop & (count != '0);

  // Flush wins over everything; a pop in the same cycle is already consumed downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + LVL_W'(push) - LVL_W'(do_pop);
    end
  end

  assign level = count;
  assign valid = (count != '0);
  assign head  = mem[rd_ptr];

  push_not_full: assert property (@(posedge clk) disable iff (!rst_n)
    (push && !flush) |-> (count != LVL_W'(DEPTH)));
endmodule

// File: rtl/d16_fetch.sv
// Prefetching instruction fetch: 2 cycles from issue (or jump) to out_valid, 1 instr/cycle sustained.
// Issues a read only when the queue has credit for it; a taken jump flushes and refetches.
module d16_fetch
  import d16_fetch_pkg::*;
#(
  parameter int                ADDR_W     = D16_ADDR_W,
  parameter int                INS_W      = D16_INS_W,
  parameter int                DEPTH      = D16_DEPTH,
  parameter int                STEP       = D16_INS_STEP,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(D16_RESET_ADDR)
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  d16_fetch_if.master    bus
);
  localparam int                LVL_W   = lvl_w(DEPTH);
  localparam logic [ADDR_W-1:0] STEP_A  = ADDR_W'(STEP);
  localparam logic [LVL_W:0]    DEPTH_C = (LVL_W+1)'(DEPTH);

  logic [ADDR_W-1:0]        fa;
  logic [ADDR_W-1:0]        req_pc;
  logic                     req_q;
  logic                     pop;
  logic                     push;
  logic                     issue;
  logic [LVL_W:0]           need;
  logic [LVL_W-1:0]         level;
  logic                     head_vld;
  logic [ADDR_W+INS_W-1:0]  head;

  assign pop = head_vld & bus.out_ready;

  // Slots already committed: queued words plus the one in flight, minus the word leaving now.
  assign need  = {1'b0, level} + (LVL_W+1)'(req_q) - (LVL_W+1)'(pop);
  assign issue = bus.jmp | (need < DEPTH_C);
  assign push  = req_q & ~bus.jmp;

  assign bus.ins_a  = bus.jmp ? bus.jmp_adr : fa;
  assign bus.ins_re = issue;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      fa     <= RESET_ADDR;
      req_q  <= 1'b0;
      req_pc <= '0;
    end else begin
      req_q <= issue;
      if (issue) begin
        fa     <= bus.ins_a + STEP_A;
        req_pc <= bus.ins_a;
      end
    end
  end

  d16_fifo #(
    .WIDTH (ADDR_W + INS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .rst_n (sys_rst),
    .push  (push),
    .din   ({req_pc, bus.ins_di}),
    .pop   (pop),
    .flush (bus.jmp),
    .level (level),
    .valid (head_vld),
    .head  (head)
  );

  assign bus.out_valid              = head_vld;
  assign {bus.out_pc, bus.out_ins}  = head;
  assign bus.level                  = level;
endmodule

// File: tb/tb_d16_fetch.sv
// Bench for d16_fetch: queue-level reference model checked every cycle plus directed literal checks.
module tb_d16_fetch;
  localparam int DEPTH = 4;
  localparam int STEP  = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  d16_fetch_if #(.ADDR_W(16), .INS_W(32), .DEPTH(DEPTH)) bus  ();
  d16_fetch_if #(.ADDR_W(16), .INS_W(32), .DEPTH(DEPTH)) bus2 ();

  d16_fetch #(.ADDR_W(16), .INS_W(32), .DEPTH(DEPTH), .STEP(STEP), .RESET_ADDR(16'h0000)) u_dut (
    .sys_clk (clk),
    .sys_rst (rst_n),
    .bus     (bus)
  );

  d16_fetch #(.ADDR_W(16), .INS_W(32), .DEPTH(DEPTH), .STEP(STEP), .RESET_ADDR(16'hFFF8)) u_dut2 (
    .sys_clk (clk),
    .sys_rst (rst_n),
    .bus     (bus2)
  );

  // Synchronous memories: the word for address a is {~a, a}, one cycle after a is presented.
  always @(posedge clk) begin
    bus.ins_di  <= {~bus.ins_a, bus.ins_a};
    bus2.ins_di <= {~bus2.ins_a, bus2.ins_a};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of fetched PCs, an in-flight read, the next sequential address,
  // and the program-order PC the consumer must see next.
  logic [15:0] mq[$];
  bit          m_inflight;
  logic [15:0] m_req_pc;
  logic [15:0] m_fa;
  logic [15:0] exp_next;

  always @(negedge clk) begin
    bit          e_valid;
    bit          e_pop;
    bit          e_re;
    logic [15:0] e_a;
    logic [15:0] e_pc;
    if (!rst_n) begin
      mq.delete();
      m_inflight = 1'b0;
      m_req_pc   = 16'h0;
      m_fa       = 16'h0000;
      exp_next   = 16'h0000;
    end
    e_valid = (mq.size() > 0);
    e_pc    = e_valid ? mq[0] : 16'h0;
    e_pop   = e_valid && bus.out_ready;
    e_re    = bus.jmp || (int'(mq.size()) + int'(m_inflight) - int'(e_pop) < DEPTH);
    e_a     = bus.jmp ? bus.jmp_adr : m_fa;

    chk("model_valid", bus.out_valid, e_valid);
    chk("model_level", bus.level, mq.size());
    chk("model_ins_re", bus.ins_re, e_re);
    chk("model_ins_a", bus.ins_a, e_a);
    if (e_valid) begin
      chk("model_pc", bus.out_pc, e_pc);
      chk("model_ins", bus.out_ins, {~e_pc, e_pc});
    end
    if (rst_n && e_pop) begin
      chk("order_pc", bus.out_pc, exp_next);
      exp_next = exp_next + 16'(STEP);
    end

    if (rst_n) begin
      if (e_pop) void'(mq.pop_front());
      if (bus.jmp) begin
        mq.delete();
        exp_next = bus.jmp_adr;
      end else if (m_inflight) begin
        mq.push_back(m_req_pc);
      end
      m_inflight = e_re;
      if (e_re) begin
        m_req_pc = e_a;
        m_fa     = e_a + 16'(STEP);
      end
    end
  end

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.jmp        = 1'b0;
    bus.jmp_adr    = 16'h0;
    bus.out_ready  = 1'b0;
    bus2.jmp       = 1'b0;
    bus2.jmp_adr   = 16'h0;
    bus2.out_ready = 1'b1;

    // Reset state and streaming with out_ready held high.
    adv(2);
    smp();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_level", bus.level, 0);
    chk("rst_ins_a", bus.ins_a, 16'h0000);
    chk("rst_pc", bus.out_pc, 16'h0000);
    chk("rst_ins", bus.out_ins, 32'h0);
    adv(1); rst_n = 1'b1; bus.out_ready = 1'b1;
    smp();
    chk("c0_ins_a", bus.ins_a, 16'h0000);
    chk("c0_ins_re", bus.ins_re, 1);
    adv(1); smp();
    chk("c1_valid", bus.out_valid, 0);
    chk("c1_valid2", bus2.out_valid, 0);
    adv(1); smp();
    chk("c2_valid", bus.out_valid, 1);
    chk("c2_pc", bus.out_pc, 16'h0000);
    chk("c2_ins", bus.out_ins, 32'hFFFF_0000);
    chk("c2_level", bus.level, 1);
    chk("c2_pc2", bus2.out_pc, 16'hFFF8);
    adv(1); smp();
    chk("c3_pc", bus.out_pc, 16'h0004);
    chk("c3_level", bus.level, 1);
    chk("c3_pc2", bus2.out_pc, 16'hFFFC);
    adv(1); smp();
    chk("c4_pc", bus.out_pc, 16'h0008);
    chk("c4_pc2", bus2.out_pc, 16'h0000);
    chk("c4_ins2", bus2.out_ins, 32'hFFFF_0000);
    adv(1); smp();
    chk("c5_pc", bus.out_pc, 16'h000C);
    chk("c5_pc2", bus2.out_pc, 16'h0004);
    chk("c5_valid2", bus2.out_valid, 1);

    // Backpressure from reset: exactly DEPTH fetches, then resume without a gap.
    adv(1); rst_n = 1'b0; bus.out_ready = 1'b0;
    adv(2); rst_n = 1'b1;
    adv(6); smp();
    chk("bp_ins_re", bus.ins_re, 0);
    chk("bp_level", bus.level, 4);
    chk("bp_fa", bus.ins_a, 16'h0010);
    chk("bp_pc", bus.out_pc, 16'h0000);
    adv(1); bus.out_ready = 1'b1; smp();
    chk("bp_resume_pc", bus.out_pc, 16'h0000);
    adv(4); smp();
    chk("bp_16_valid", bus.out_valid, 1);
    chk("bp_16_pc", bus.out_pc, 16'h0010);

    // Jump with level 3 and a read in flight, then a jump that coincides with a pop.
    adv(1); rst_n = 1'b0; bus.out_ready = 1'b0;
    adv(2); rst_n = 1'b1;
    adv(4); bus.jmp = 1'b1; bus.jmp_adr = 16'h0100; smp();
    chk("j_level", bus.level, 3);
    chk("j_ins_a", bus.ins_a, 16'h0100);
    chk("j_ins_re", bus.ins_re, 1);
    adv(1); bus.jmp = 1'b0; smp();
    chk("j1_valid", bus.out_valid, 0);
    chk("j1_level", bus.level, 0);
    adv(1); smp();
    chk("j2_valid", bus.out_valid, 1);
    chk("j2_pc", bus.out_pc, 16'h0100);
    adv(1); bus.out_ready = 1'b1; smp();
    chk("j3_pc", bus.out_pc, 16'h0100);
    adv(1); smp();
    chk("j4_pc", bus.out_pc, 16'h0104);
    adv(1); bus.jmp = 1'b1; bus.jmp_adr = 16'h0200; smp();
    chk("jp_pc", bus.out_pc, 16'h0108);
    chk("jp_valid", bus.out_valid, 1);
    adv(1); bus.jmp = 1'b0; smp();
    chk("jp1_valid", bus.out_valid, 0);
    chk("jp1_level", bus.level, 0);
    adv(1); smp();
    chk("jp2_pc", bus.out_pc, 16'h0200);
    adv(1); smp();
    chk("jp3_pc", bus.out_pc, 16'h0204);

    // Asynchronous reset mid-stream with two words queued.
    adv(1); rst_n = 1'b0; bus.out_ready = 1'b0;
    adv(2); rst_n = 1'b1;
    adv(3); smp();
    chk("ar_level_before", bus.level, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid_async", bus.out_valid, 0);
    chk("ar_level_async", bus.level, 0);
    adv(2); rst_n = 1'b1; bus.out_ready = 1'b1; smp();
    chk("ar_c0_ins_a", bus.ins_a, 16'h0000);
    adv(1); smp();
    chk("ar_c1_valid", bus.out_valid, 0);
    adv(1); smp();
    chk("ar_c2_valid", bus.out_valid, 1);
    chk("ar_c2_pc", bus.out_pc, 16'h0000);
    adv(5); smp();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
